cluster_expander: RTL and testbench

Receive-side counterpart of the cluster counting and packing path. It accepts a stream of cluster words (start pad address plus size) on `clock4x` and rebuilds the 1536-bit valid-pad-flag (vpf) bitmap for each frame. Alongside the bitmap it reports the number of clusters received, an overflow flag using the same threshold as the cluster counter, and error flags. It sits after the link receiver in the readout/emulation chain, and on the test fixture it lets frames be compared bit-for-bit against the vpfs that fed the packer.

---
 rtl/cluster_expander_pkg.sv | 18 +
 rtl/cluster_expander_mask_decode.sv | 31 +++
 rtl/cluster_expander.sv | 117 +++++++++++
 tb/tb_cluster_expander.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cluster_expander_pkg.sv
// Shared frame geometry and control types for the cluster expander.
package global_definitions;

    localparam int MXPADS     = 1536;
    localparam int MXADRBITS  = 11;
    localparam int MXCNTBITS  = 3;
    localparam int MXCLUSTERS = 8;

    typedef enum logic {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] n);
        return (n == 8'hFF) ? n : n + 8'd1;
    endfunction

endpackage

// File: rtl/cluster_expander_mask_decode.sv
// Combinational decode of one cluster word into a pad mask plus range flags.
module cluster_mask_decode #(
    parameter int MXPADS    = global_definitions::MXPADS,
    parameter int MXADRBITS = global_definitions::MXADRBITS,
    parameter int MXCNTBITS = global_definitions::MXCNTBITS
) (
    input  logic [MXADRBITS-1:0] adr,
    input  logic [MXCNTBITS-1:0] cnt,
    output logic [MXPADS-1:0]    mask,
    output logic                 err_adr,
    output logic                 err_clip
);

    localparam int AW = MXADRBITS + 1;

    logic [AW-1:0] lo;
    logic [AW-1:0] hi;
    logic          adr_ok;

    // One extra bit keeps adr+cnt from wrapping back into the pad range.
    assign lo       = {1'b0, adr};
    assign hi       = lo + AW'(cnt);
    assign adr_ok   = lo < AW'(MXPADS);
    assign err_adr  = !adr_ok;
    assign err_clip = adr_ok && (hi >= AW'(MXPADS));

    for (genvar i = 0; i < MXPADS; i++) begin : g_pad
        assign mask[i] = adr_ok && (lo <= AW'(i)) && (hi >= AW'(i));
    end

endmodule

// File: rtl/cluster_expander.sv
// Rebuilds the per-frame vpf bitmap from a stream of cluster words and
// reports cluster count, overflow and address/clip error flags.
module cluster_expander #(
    parameter int MXPADS     = global_definitions::MXPADS,
    parameter int MXADRBITS  = global_definitions::MXADRBITS,
    parameter int MXCNTBITS  = global_definitions::MXCNTBITS,
    parameter int MXCLUSTERS = global_definitions::MXCLUSTERS
) (
    input  logic                 clock4x,
    input  logic                 reset_n,
    input  logic                 cluster_vld,
    input  logic [MXADRBITS-1:0] cluster_adr,
    input  logic [MXCNTBITS-1:0] cluster_cnt,
    input  logic                 frame_end,
    output logic [MXPADS-1:0]    vpfs,
    output logic                 vpfs_vld,
    output logic [7:0]           n_clusters,
    output logic                 overflow,
    output logic                 err_adr,
    output logic                 err_clip
);

    import global_definitions::*;

    logic [1:0]        rst_sync;
    logic              rst_n;
    logic [MXPADS-1:0] mask;
    logic              mask_eadr;
    logic              mask_eclip;
    logic [MXPADS-1:0] acc, acc_upd;
    logic [7:0]        acc_n, n_upd;
    logic              acc_eadr, eadr_upd;
    logic              acc_eclip, eclip_upd;
    state_t            state, state_nxt;

    // Assert asynchronously, release on a clock edge so every flop leaves reset together.
    always_ff @(posedge clock4x or negedge reset_n) begin
        if (!reset_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    cluster_mask_decode #(
        .MXPADS    (MXPADS),
        .MXADRBITS (MXADRBITS),
        .MXCNTBITS (MXCNTBITS)
    ) u_decode (
        .adr      (cluster_adr),
        .cnt      (cluster_cnt),
        .mask     (mask),
        .err_adr  (mask_eadr),
        .err_clip (mask_eclip)
    );

    // Accumulator contents including this cycle's cluster, so a cluster that
    // coincides with frame_end lands in the closing frame.
    always_comb begin
        acc_upd   = acc;
        n_upd     = acc_n;
        eadr_upd  = acc_eadr;
        eclip_upd = acc_eclip;
        if (cluster_vld) begin
            acc_upd   = acc | mask;
            n_upd     = sat_inc8(acc_n);
            eadr_upd  = acc_eadr | mask_eadr;
            eclip_upd = acc_eclip | mask_eclip;
        end
    end

    always_ff @(posedge clock4x or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            acc_n     <= '0;
            acc_eadr  <= 1'b0;
            acc_eclip <= 1'b0;
        end else if (frame_end) begin
            acc       <= '0;
            acc_n     <= '0;
            acc_eadr  <= 1'b0;
            acc_eclip <= 1'b0;
        end else begin
            acc       <= acc_upd;
            acc_n     <= n_upd;
            acc_eadr  <= eadr_upd;
            acc_eclip <= eclip_upd;
        end
    end

    always_ff @(posedge clock4x or negedge rst_n) begin
        if (!rst_n) begin
            vpfs       <= '0;
            n_clusters <= '0;
            overflow   <= 1'b0;
            err_adr    <= 1'b0;
            err_clip   <= 1'b0;
        end else if (frame_end) begin
            vpfs       <= acc_upd;
            n_clusters <= n_upd;
            overflow   <= n_upd > 8'(MXCLUSTERS);
            err_adr    <= eadr_upd;
            err_clip   <= eclip_upd;
        end
    end

    always_ff @(posedge clock4x or negedge rst_n) begin
        if (!rst_n) state <= ACCUM;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = ACCUM;
        vpfs_vld  = 1'b0;
        if (frame_end) state_nxt = EMIT;
        if (state == EMIT) vpfs_vld = 1'b1;
    end

endmodule

// File: tb/tb_cluster_expander.sv
// Directed table, reset sequence and randomly clustered bitmaps for cluster_expander.
module tb_cluster_expander;

    localparam int NP = 1536;

    logic          clock4x = 1'b0;
    logic          reset_n = 1'b0;
    logic          cluster_vld = 1'b0;
    logic [10:0]   cluster_adr = '0;
    logic [2:0]    cluster_cnt = '0;
    logic          frame_end = 1'b0;
    logic [NP-1:0] vpfs;
    logic          vpfs_vld;
    logic [7:0]    n_clusters;
    logic          overflow;
    logic          err_adr;
    logic          err_clip;

    cluster_expander dut (
        .clock4x     (clock4x),
        .reset_n     (reset_n),
        .cluster_vld (cluster_vld),
        .cluster_adr (cluster_adr),
        .cluster_cnt (cluster_cnt),
        .frame_end   (frame_end),
        .vpfs        (vpfs),
        .vpfs_vld    (vpfs_vld),
        .n_clusters  (n_clusters),
        .overflow    (overflow),
        .err_adr     (err_adr),
        .err_clip    (err_clip)
    );

    always #5 clock4x = ~clock4x;

    typedef struct {
        bit vld; int adr; int cnt; bit fe;
        int lo; int hi;
        int n; bit ovf; bit eadr; bit eclip; int pop;
    } row_t;

    int n_cmp = 0;
    int n_bad = 0;
    row_t tbl[$];
    logic [NP-1:0] exp_bm, last_bm, src;
    int q_adr[$];
    int q_cnt[$];
    int run_len, start, len;

    function automatic row_t mk(bit vld, int adr, int cnt, bit fe, int lo, int hi,
                                int n, bit ovf, bit eadr, bit eclip, int pop);
        row_t r;
        r.vld = vld; r.adr = adr; r.cnt = cnt; r.fe = fe; r.lo = lo; r.hi = hi;
        r.n = n; r.ovf = ovf; r.eadr = eadr; r.eclip = eclip; r.pop = pop;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_bm(input string name, input logic [NP-1:0] exp);
        int first;
        n_cmp++;
        if (vpfs !== exp) begin
            n_bad++;
            first = -1;
            for (int i = NP - 1; i >= 0; i--) if (vpfs[i] !== exp[i]) first = i;
            $display("FAIL %s: bitmap differs first at bit %0d (got %0d expected %0d), popcount got %0d expected %0d",
                     name, first, vpfs[first], exp[first], $countones(vpfs), $countones(exp));
        end
    endtask

    task automatic drive(input bit vld, input int adr, input int cnt, input bit fe);
        @(negedge clock4x);
        cluster_vld = vld;
        cluster_adr = 11'(adr);
        cluster_cnt = 3'(cnt);
        frame_end   = fe;
    endtask

    initial begin
        // frame A: (0,0) (100,7) (1535,0)
        tbl.push_back(mk(1, 0,    0, 0, 0,    0,    0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 100,  7, 0, 100,  107,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1535, 0, 0, 1535, 1535, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0,    0, 1, -1,   -1,   3, 0, 0, 0, 10));
        // frame B: nine 2-pad clusters, frame_end with the ninth
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(1, 10 * k, 1, 0, 10 * k, 10 * k + 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 80, 1, 1, 80, 81, 9, 1, 0, 0, 18));
        // frame C: clipped cluster and out-of-range cluster
        tbl.push_back(mk(1, 1530, 7, 0, 1530, 1535, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1600, 3, 1, -1,   -1,   2, 0, 1, 1, 6));
        // back-to-back frame_end
        tbl.push_back(mk(1, 5, 2, 1, 5,  7,  1, 0, 0, 0, 3));
        tbl.push_back(mk(0, 0, 0, 1, -1, -1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, -1, -1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, -1, -1, 0, 0, 0, 0, 0));

        // reset state
        repeat (2) @(negedge clock4x);
        chk("rst_vld", int'(vpfs_vld), 0);
        chk("rst_n", int'(n_clusters), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_eadr", int'(err_adr), 0);
        chk("rst_eclip", int'(err_clip), 0);
        chk_bm("rst_bm", '0);
        reset_n = 1'b1;
        repeat (3) @(negedge clock4x);

        exp_bm  = '0;
        last_bm = '0;
        foreach (tbl[r]) begin
            drive(tbl[r].vld, tbl[r].adr, tbl[r].cnt, tbl[r].fe);
            if (tbl[r].lo >= 0)
                for (int b = tbl[r].lo; b <= tbl[r].hi; b++) exp_bm[b] = 1'b1;
            @(posedge clock4x);
            #1;
            chk($sformatf("row%0d_vld", r), int'(vpfs_vld), int'(tbl[r].fe));
            if (tbl[r].fe) begin
                chk($sformatf("row%0d_n", r), int'(n_clusters), tbl[r].n);
                chk($sformatf("row%0d_ovf", r), int'(overflow), int'(tbl[r].ovf));
                chk($sformatf("row%0d_eadr", r), int'(err_adr), int'(tbl[r].eadr));
                chk($sformatf("row%0d_eclip", r), int'(err_clip), int'(tbl[r].eclip));
                chk($sformatf("row%0d_pop", r), $countones(vpfs), tbl[r].pop);
                chk_bm($sformatf("row%0d_bm", r), exp_bm);
                last_bm = exp_bm;
                exp_bm  = '0;
            end else begin
                chk_bm($sformatf("row%0d_hold", r), last_bm);
            end
        end

        // reset during a partially built frame
        drive(1, 300, 4, 1);
        @(posedge clock4x); #1;
        chk("pre_rst_n", int'(n_clusters), 1);
        for (int k = 0; k < 4; k++) drive(1, 200 + k, 3, 0);
        drive(0, 0, 0, 0);
        #1 reset_n = 1'b0;
        #1;
        chk("in_rst_n", int'(n_clusters), 0);
        chk_bm("in_rst_bm", '0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock4x);
            chk("in_rst_vld", int'(vpfs_vld), 0);
            chk("in_rst_n_hold", int'(n_clusters), 0);
        end
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock4x);
            chk("post_rst_vld", int'(vpfs_vld), 0);
        end
        drive(1, 20, 0, 1);
        @(posedge clock4x); #1;
        exp_bm = '0;
        exp_bm[20] = 1'b1;
        chk("post_rst_strobe", int'(vpfs_vld), 1);
        chk("post_rst_n", int'(n_clusters), 1);
        chk_bm("post_rst_bm", exp_bm);
        drive(0, 0, 0, 0);

        // random bitmaps clustered by a reference scan
        for (int f = 0; f < 4; f++) begin
            src = '0;
            for (int i = 0; i < NP; i++) begin
                if ($urandom_range(0, 39) == 0) begin
                    run_len = int'($urandom_range(1, 12));
                    for (int j = 0; j < run_len && i + j < NP; j++) src[i + j] = 1'b1;
                end
            end
            if (src == '0) src[$urandom_range(0, NP - 1)] = 1'b1;
            q_adr.delete();
            q_cnt.delete();
            for (int i = 0; i < NP; ) begin
                if (src[i]) begin
                    start = i;
                    len = 0;
                    while (i < NP && src[i] && len < 8) begin i++; len++; end
                    q_adr.push_back(start);
                    q_cnt.push_back(len - 1);
                end else begin
                    i++;
                end
            end
            foreach (q_adr[c]) begin
                drive(1, q_adr[c], q_cnt[c], (f % 2 == 0) && (c == q_adr.size() - 1));
            end
            if (f % 2 == 1) drive(0, 0, 0, 1);
            @(posedge clock4x); #1;
            chk($sformatf("rnd%0d_vld", f), int'(vpfs_vld), 1);
            chk($sformatf("rnd%0d_n", f), int'(n_clusters), (q_adr.size() > 255) ? 255 : q_adr.size());
            chk_bm($sformatf("rnd%0d_bm", f), src);
            drive(0, 0, 0, 0);
        end

        repeat (2) @(negedge clock4x);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
